// File: rtl/stitch_pipeline_pkg.sv
// rtl/stitch_pipeline_pkg.sv - stage constants and slot/occupancy sizing helpers for stitch_pipeline_rv
package stitch_pipeline_pkg;

    localparam int STAGE_INC_W = 256;

    // Stage k adds 1 << k; shifts past the datapath width collapse to zero.
    function automatic logic [STAGE_INC_W-1:0] stage_inc(input int k, input int data_w);
        logic [STAGE_INC_W-1:0] v;
        v = '0;
        if (k >= 0 && k < data_w && k < STAGE_INC_W) begin
            v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic int num_slots(input int num_stages, input bit io_flops);
        return io_flops ? num_stages + 1 : num_stages - 1;
    endfunction

    function automatic int occ_width(input int num_stages);
        return $clog2(num_stages + 2);
    endfunction

endpackage

// File: rtl/stitch_pipeline_rv_if.sv
// rtl/stitch_pipeline_rv_if.sv - producer/consumer handshake bundle for stitch_pipeline_rv
interface stitch_pipeline_rv_if #(
    parameter int DATA_W = 32
);
    logic              input_valid;
    logic              input_ready;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] out;
    logic              output_valid;
    logic              output_ready;

    modport master (
        output input_valid, x, output_ready,
        input  input_ready, out, output_valid
    );

    modport slave (
        input  input_valid, x, output_ready,
        output input_ready, out, output_valid
    );
endinterface

// File: rtl/stitch_pipe_slot.sv
// rtl/stitch_pipe_slot.sv - one valid/data pipeline register slot with load enable from the ready chain
module stitch_pipe_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
        end
    end

    // Data is left unreset; it is only observed while valid is set.
    always_ff @(posedge clk) begin
        if (ready && up_valid) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/stitch_pipeline_rv.sv
// rtl/stitch_pipeline_rv.sv - NUM_STAGES adder stages with valid/ready slots; STITCH_PIPELINE_IO_FLOPS_EN adds input/output slots
module stitch_pipeline_rv
    import stitch_pipeline_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    stitch_pipeline_rv_if.slave               bus,
    output logic [occ_width(NUM_STAGES)-1:0]  occupancy
);

`ifdef STITCH_PIPELINE_IO_FLOPS_EN
    localparam bit IO_FLOPS = 1'b1;
`else
    localparam bit IO_FLOPS = 1'b0;
`endif
    localparam int R     = num_slots(NUM_STAGES, IO_FLOPS);
    localparam int OCC_W = occ_width(NUM_STAGES);

    logic [R-1:0]      slot_v;
    logic [R-1:0]      slot_uv;
    logic [R-1:0]      slot_vn;
    logic [R-1:0]      slot_ready;
    logic [DATA_W-1:0] slot_d [R];
    logic [DATA_W-1:0] slot_q [R];
    logic [DATA_W-1:0] stage_in  [NUM_STAGES];
    logic [DATA_W-1:0] stage_out [NUM_STAGES];
    logic [OCC_W-1:0]  occ_next;

    // Ready ripples back from the consumer: a slot loads if empty or if its successor loads.
    always_comb begin
        logic nxt;
        nxt = bus.output_ready;
        slot_ready = '0;
        for (int i = R - 1; i >= 0; i--) begin
            nxt = !slot_v[i] || nxt;
            slot_ready[i] = nxt;
        end
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < R; i++) begin
            slot_vn[i] = slot_ready[i] ? slot_uv[i] : slot_v[i];
            occ_next   = occ_next + OCC_W'(slot_vn[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    for (genvar i = 0; i < R; i++) begin : g_slot
        if (i == 0) begin : g_first
            assign slot_uv[i] = bus.input_valid;
        end else begin : g_rest
            assign slot_uv[i] = slot_v[i-1];
        end

`ifdef STITCH_PIPELINE_IO_FLOPS_EN
        if (i == 0) begin : g_din_x
            assign slot_d[i] = bus.x;
        end else begin : g_din_stage
            assign slot_d[i] = stage_out[i-1];
        end
`else
        assign slot_d[i] = stage_out[i];
`endif

        stitch_pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .up_valid (slot_uv[i]),
            .up_data  (slot_d[i]),
            .ready    (slot_ready[i]),
            .valid    (slot_v[i]),
            .data     (slot_q[i])
        );
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam logic [DATA_W-1:0] INC = DATA_W'(stage_inc(k, DATA_W));

`ifdef STITCH_PIPELINE_IO_FLOPS_EN
        assign stage_in[k] = slot_q[k];
`else
        if (k == 0) begin : g_in_x
            assign stage_in[k] = bus.x;
        end else begin : g_in_slot
            assign stage_in[k] = slot_q[k-1];
        end
`endif

        assign stage_out[k] = stage_in[k] + INC;
    end

    assign bus.input_ready  = slot_ready[0];
    assign bus.output_valid = slot_v[R-1];
`ifdef STITCH_PIPELINE_IO_FLOPS_EN
    assign bus.out = slot_q[R-1];
`else
    assign bus.out = stage_out[NUM_STAGES-1];
`endif

endmodule
